data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_pkg.sv | 21 ++
 rtl/data_mem_arbiter_rr_picker.sv | 31 +++
 rtl/data_mem_arbiter.sv | 109 ++++++++++
 tb/tb_data_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, FSM state
// encoding and a small index-width helper.
package data_mem_arbiter_pkg;

    localparam int NUM_THREADS = 4;
    localparam int ADDR_WIDTH  = 8;
    localparam int DATA_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Thread-index width; a single requester still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_picker.sv
// Round-robin winner selection: first asserted request at or above rr_ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_picker
    import data_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_THREADS,
    parameter int IW      = idx_width(NUM_THREADS)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic               grant_valid,
    output logic [IW-1:0]      grant_idx
);

    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-outstanding arbiter between NUM_REQ threads and one data memory.
// IDLE picks a winner round-robin and latches its request, ISSUE holds it on
// the memory port, WAIT collects the completion, RESP returns it to the owner.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_THREADS,
    parameter int AW      = ADDR_WIDTH,
    parameter int DW      = DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [NUM_REQ*AW-1:0]  req_addr,
    input  logic [NUM_REQ*DW-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [DW-1:0]          rsp_rdata,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic                   mem_rsp_valid,
    input  logic [DW-1:0]          mem_rdata,
    output logic                   busy,
    output logic                   spurious_rsp
);

    localparam int IW = idx_width(NUM_REQ);

    arb_state_t                  state;
    logic [IW-1:0]               rr_ptr;
    logic [IW-1:0]               owner;
    logic [IW-1:0]               owner_next;
    logic [IW-1:0]               grant_idx;
    logic                        grant_valid;
    logic [DW-1:0]               rdata_q;
    logic [NUM_REQ-1:0][AW-1:0]  addr_arr;
    logic [NUM_REQ-1:0][DW-1:0]  wdata_arr;

    assign addr_arr  = req_addr;
    assign wdata_arr = req_wdata;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign owner_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // Transaction FSM plus latched request fields, capture data and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rdata_q      <= '0;
            spurious_rsp <= 1'b0;
        end else begin
            if (mem_rsp_valid && state != ST_WAIT)
                spurious_rsp <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant_idx;
                        mem_we    <= req_we[grant_idx];
                        mem_addr  <= addr_arr[grant_idx];
                        mem_wdata <= wdata_arr[grant_idx];
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        rdata_q <= mem_we ? '0 : mem_rdata;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rr_ptr <= owner_next;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state; accept is suppressed while in reset.
    assign req_ready     = (!reset && state == ST_IDLE && grant_valid)
                           ? (NUM_REQ'(1) << grant_idx) : '0;
    assign rsp_valid     = (state == ST_RESP) ? (NUM_REQ'(1) << owner) : '0;
    assign rsp_rdata     = rdata_q;
    assign mem_req_valid = (state == ST_ISSUE);
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_data_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0]        req_we = '0;
    logic [N-1:0][AW-1:0] req_addr_a = '0;
    logic [N-1:0][DW-1:0] req_wdata_a = '0;
    logic [N-1:0]        req_ready, rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic                mem_req_valid, mem_we, mem_rsp_valid;
    logic                mem_req_ready = 1'b0;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata, mem_rdata;
    logic                busy, spurious_rsp;

    // Memory side: either driven by hand or by an auto responder that
    // completes one cycle after each accepted request.
    logic                auto_mem = 1'b0;
    logic                man_rsp = 1'b0;
    logic [DW-1:0]       man_rdata = '0;
    logic                pend = 1'b0;
    logic [DW-1:0]       pend_data = '0;
    assign mem_rsp_valid = auto_mem ? pend : man_rsp;
    assign mem_rdata     = auto_mem ? pend_data : man_rdata;

    data_mem_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr_a),
        .req_wdata     (req_wdata_a),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .spurious_rsp  (spurious_rsp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pend      <= mem_req_valid && mem_req_ready;
        pend_data <= {8'hC3, mem_addr};
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit            m_init = 0, m_act = 0, m_iss = 0, m_done = 0, m_spur = 0;
    int            m_own = 0, m_ptr = 0;
    logic          m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0, m_rd = '0;

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int w;
        if (reset) begin
            m_init <= 1; m_act <= 0; m_iss <= 0; m_done <= 0; m_spur <= 0;
            m_ptr <= 0; m_rd <= '0; m_we <= 0; m_addr <= '0; m_wd <= '0;
        end else begin
            if (mem_rsp_valid && !(m_act && m_iss && !m_done)) m_spur <= 1;
            if (!m_act) begin
                w = winner(req_valid, m_ptr);
                if (w >= 0) begin
                    m_act <= 1; m_own <= w; m_we <= req_we[w];
                    m_addr <= req_addr_a[w]; m_wd <= req_wdata_a[w];
                end
            end else if (!m_iss) begin
                if (mem_req_ready) m_iss <= 1;
            end else if (!m_done) begin
                if (mem_rsp_valid) begin
                    m_done <= 1;
                    m_rd   <= m_we ? '0 : mem_rdata;
                end
            end else begin
                m_act <= 0; m_iss <= 0; m_done <= 0;
                m_ptr <= (m_own + 1) % N;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin : compare
        logic [N-1:0] e_rdy, e_rsp;
        int w;
        if (m_init) begin
            e_rdy = '0;
            if (!reset && !m_act) begin
                w = winner(req_valid, m_ptr);
                if (w >= 0) e_rdy = N'(1) << w;
            end
            e_rsp = (m_act && m_done) ? (N'(1) << m_own) : '0;
            chk("m_req_ready", 64'(req_ready), 64'(e_rdy));
            chk("m_rsp_valid", 64'(rsp_valid), 64'(e_rsp));
            chk("m_mem_req_valid", 64'(mem_req_valid), 64'(m_act && !m_iss));
            chk("m_busy", 64'(busy), 64'(m_act));
            chk("m_spurious", 64'(spurious_rsp), 64'(m_spur));
            if (e_rsp != '0) chk("m_rsp_rdata", 64'(rsp_rdata), 64'(m_rd));
            if (m_act && !m_iss) begin
                chk("m_mem_we", 64'(mem_we), 64'(m_we));
                chk("m_mem_addr", 64'(mem_addr), 64'(m_addr));
                chk("m_mem_wdata", 64'(mem_wdata), 64'(m_wd));
            end
        end
    end

    // Observation of DUT events for scenario-level checks.
    int hs_cnt = 0;
    int rsp_cnt3 = 0;
    int dut_grants[$];
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) dut_grants.push_back(k);
        if (mem_req_valid && mem_req_ready) hs_cnt++;
        if (rsp_valid[3]) rsp_cnt3++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int k, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[k] = 1'b1; req_we[k] = we; req_addr_a[k] = a; req_wdata_a[k] = d;
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'(0));
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_spurious"}, 64'(spurious_rsp), 64'(0));
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        @(negedge clk);
        while (busy && c < 50) begin @(negedge clk); c++; end
        chk({tag, "_idle_timeout"}, 64'(busy), 64'(0));
        tick();
    endtask

    task automatic wait_grants(input int n, input string tag);
        int c = 0;
        while (dut_grants.size() < n && c < 200) begin @(negedge clk); c++; end
        chk({tag, "_grant_timeout"}, 64'(dut_grants.size() >= n), 64'(1));
        tick();
    endtask

    initial begin : stim
        int exp_g[5];
        int hs0, r30;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); zero_check("rst");
        tick(); reset = 0;

        // Single read from thread 2
        mem_req_ready = 1; set_req(2, 1'b0, 8'h05, 16'h0);
        @(negedge clk); chk("rd_req_ready", 64'(req_ready), 64'(4'b0100));
        tick(); req_valid[2] = 0;
        @(negedge clk);
        chk("rd_mem_req_valid", 64'(mem_req_valid), 64'(1));
        chk("rd_mem_addr", 64'(mem_addr), 64'(8'h05));
        tick(); man_rsp = 1; man_rdata = 16'h1234;
        tick(); man_rsp = 0;
        @(negedge clk);
        chk("rd_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'(16'h1234));
        wait_idle("rd");

        // Write from thread 1 with 3 cycles of backpressure
        mem_req_ready = 0; set_req(1, 1'b1, 8'h0A, 16'hBEEF); hs0 = hs_cnt;
        @(negedge clk); chk("wr_req_ready", 64'(req_ready), 64'(4'b0010));
        tick(); req_valid[1] = 0; req_we[1] = 0; req_addr_a[1] = 8'hFF; req_wdata_a[1] = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wr_hold_valid", 64'(mem_req_valid), 64'(1));
            chk("wr_hold_we", 64'(mem_we), 64'(1));
            chk("wr_hold_addr", 64'(mem_addr), 64'(8'h0A));
            chk("wr_hold_wdata", 64'(mem_wdata), 64'(16'hBEEF));
            tick();
        end
        mem_req_ready = 1;
        tick(); mem_req_ready = 0; man_rsp = 1; man_rdata = 16'hDEAD;
        tick(); man_rsp = 0;
        @(negedge clk);
        chk("wr_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
        chk("wr_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("wr_accept_count", 64'(hs_cnt - hs0), 64'(1));
        wait_idle("wr");

        // Thread 0 arrives while thread 2 is outstanding
        mem_req_ready = 1; set_req(2, 1'b0, 8'h20, 16'h0);
        @(negedge clk); chk("mf_t2_ready", 64'(req_ready), 64'(4'b0100));
        tick(); req_valid[2] = 0;
        tick(); set_req(0, 1'b0, 8'h40, 16'h0);
        @(negedge clk); chk("mf_wait_ready", 64'(req_ready), 64'(0));
        tick(); man_rsp = 1; man_rdata = 16'h7777;
        @(negedge clk); chk("mf_wait2_ready", 64'(req_ready), 64'(0));
        tick(); man_rsp = 0;
        @(negedge clk);
        chk("mf_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        chk("mf_rsp_rdata", 64'(rsp_rdata), 64'(16'h7777));
        chk("mf_resp_ready", 64'(req_ready), 64'(0));
        tick();
        @(negedge clk); chk("mf_t0_ready", 64'(req_ready), 64'(4'b0001));
        tick(); req_valid[0] = 0; auto_mem = 1;
        wait_idle("mf");
        auto_mem = 0;

        // Spurious completion while idle
        man_rsp = 1;
        tick(); man_rsp = 0;
        @(negedge clk);
        chk("sp_flag", 64'(spurious_rsp), 64'(1));
        chk("sp_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (3) tick();
        @(negedge clk); chk("sp_sticky", 64'(spurious_rsp), 64'(1));
        tick(); reset = 1;
        tick(); reset = 0;
        @(negedge clk); chk("sp_cleared", 64'(spurious_rsp), 64'(0));
        tick();

        // Reset while thread 3 waits on memory
        mem_req_ready = 1; set_req(3, 1'b0, 8'h33, 16'h0); r30 = rsp_cnt3;
        @(negedge clk); chk("rw_t3_ready", 64'(req_ready), 64'(4'b1000));
        tick(); req_valid[3] = 0;
        tick(); reset = 1;
        tick(); reset = 0;
        @(negedge clk); zero_check("rw");
        tick(); man_rsp = 1; man_rdata = 16'h3333;
        tick(); man_rsp = 0;
        @(negedge clk); chk("rw_spurious", 64'(spurious_rsp), 64'(1));
        repeat (3) tick();
        chk("rw_no_rsp3", 64'(rsp_cnt3 - r30), 64'(0));

        // All four threads contend from reset
        reset = 1;
        for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(8'h50 + k), 16'h0);
        mem_req_ready = 1; auto_mem = 1;
        tick(); dut_grants.delete(); reset = 0;
        wait_grants(5, "rr");
        req_valid = '0;
        wait_idle("rr");
        exp_g = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            if (dut_grants.size() > k)
                chk($sformatf("rr_grant%0d", k), 64'(dut_grants[k]), 64'(exp_g[k]));

        // Lone requester is re-granted back to back
        dut_grants.delete();
        set_req(1, 1'b0, 8'h61, 16'h0);
        wait_grants(2, "lone");
        req_valid = '0;
        wait_idle("lone");
        for (int k = 0; k < 2; k++)
            if (dut_grants.size() > k)
                chk($sformatf("lone_grant%0d", k), 64'(dut_grants[k]), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
